digital_lock_core: RTL and testbench

//  Parametrised N-digit combination-lock controller; replaces the fixed 4-digit lock ASM.

---
 rtl/digital_lock_core.sv | 160 ++++++++++++++++
 tb/tb_digital_lock_core.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_lock_core.sv
// digital_lock_core: N-digit combination lock with retry lockout and confirmed code change.
// Buttons are one-cycle pulses; the lockout timer advances only on tick.
module digital_lock_core #(
    parameter int                          NUM_DIGITS    = 4,
    parameter int                          DIGIT_W       = 4,
    parameter int                          DIGIT_MAX     = 9,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int                          MAX_TRIES     = 3,
    parameter int                          LOCKOUT_TICKS = 1000
) (
    input  logic                               clk_in,
    input  logic                               rst,
    input  logic                               tick,
    input  logic                               clear,
    input  logic                               enter,
    input  logic                               change,
    input  logic [DIGIT_W-1:0]                 sw,
    output logic [NUM_DIGITS*DIGIT_W-1:0]      entry_buf,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    entry_cnt,
    output logic                               unlocked,
    output logic                               locked_out,
    output logic                               changing,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt,
    output logic                               ok_pulse,
    output logic                               err_pulse
);
    localparam int BW = NUM_DIGITS * DIGIT_W;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int TW = $clog2(LOCKOUT_TICKS + 1);
    localparam logic [CW-1:0]      FULL  = CW'(NUM_DIGITS);
    localparam logic [FW-1:0]      FMAX  = FW'(MAX_TRIES);
    localparam logic [TW-1:0]      TLAST = TW'(LOCKOUT_TICKS - 1);
    localparam logic [DIGIT_W-1:0] DMAX  = DIGIT_W'(DIGIT_MAX);

    typedef enum logic [2:0] {LOCKED, CHECK, OPEN, CHG_NEW, CHG_CONF, LOCKOUT} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] code_q, code_d, buf_q, buf_d, saved_q, saved_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fail_q, fail_d, fail_inc;
    logic [TW-1:0] timer_q, timer_d;
    logic          ok_q, ok_d, err_q, err_d;
    logic          full, entry_st;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        buf_d    = buf_q;
        saved_d  = saved_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        timer_d  = timer_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        full     = cnt_q == FULL;
        fail_inc = fail_q == FMAX ? fail_q : fail_q + 1'b1;
        entry_st = state_q == LOCKED || state_q == CHG_NEW || state_q == CHG_CONF;
        // A lower-priority button is dropped whenever a higher one is present
        if (entry_st && enter && !clear && !change && !full) begin
            if (sw > DMAX) begin
                err_d = 1'b1;
            end else begin
                buf_d = (buf_q << DIGIT_W) | BW'(sw);
                cnt_d = cnt_q + 1'b1;
            end
        end
        case (state_q)
            LOCKED: begin
                if (clear) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (full) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if (buf_q == code_q) begin
                    state_d = OPEN;
                    ok_d    = 1'b1;
                    fail_d  = '0;
                end else begin
                    err_d   = 1'b1;
                    fail_d  = fail_inc;
                    state_d = fail_inc == FMAX ? LOCKOUT : LOCKED;
                end
            end
            OPEN: begin
                if (clear) begin
                    state_d = LOCKED;
                end else if (change) begin
                    state_d = CHG_NEW;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end
            CHG_NEW: begin
                if (clear || full) begin
                    state_d = clear ? OPEN : CHG_CONF;
                    saved_d = clear ? saved_q : buf_q;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end
            CHG_CONF: begin
                if (clear || full) begin
                    state_d = OPEN;
                    buf_d   = '0;
                    cnt_d   = '0;
                    ok_d    = !clear && buf_q == saved_q;
                    err_d   = !clear && buf_q != saved_q;
                    code_d  = (!clear && buf_q == saved_q) ? buf_q : code_q;
                end
            end
            LOCKOUT: begin
                if (tick) begin
                    state_d = timer_q == TLAST ? LOCKED : LOCKOUT;
                    fail_d  = timer_q == TLAST ? '0 : fail_q;
                    timer_d = timer_q == TLAST ? '0 : timer_q + 1'b1;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q <= LOCKED;
            code_q  <= DEFAULT_CODE;
            buf_q   <= '0;
            saved_q <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            timer_q <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            buf_q   <= buf_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign entry_buf  = buf_q;
    assign entry_cnt  = cnt_q;
    assign fail_cnt   = fail_q;
    assign ok_pulse   = ok_q;
    assign err_pulse  = err_q;
    assign locked_out = state_q == LOCKOUT;
    assign changing   = state_q == CHG_NEW || state_q == CHG_CONF;
    assign unlocked   = state_q == OPEN || changing;
endmodule

// File: tb/tb_digital_lock_core.sv
// tb_digital_lock_core: directed lock scenarios plus random button traffic,
// checked every cycle against a queue-based model of the lock's rules.
module tb_digital_lock_core;
    logic        clk_in = 1'b0, rst = 1'b0, tick = 1'b0, clear = 1'b0, enter = 1'b0, change = 1'b0;
    logic [3:0]  sw = '0;
    logic [15:0] entry_buf;
    logic [2:0]  entry_cnt;
    logic        unlocked, locked_out, changing, ok_pulse, err_pulse;
    logic [1:0]  fail_cnt;

    digital_lock_core #(
        .NUM_DIGITS(4), .DIGIT_W(4), .DIGIT_MAX(9), .DEFAULT_CODE(16'h1234),
        .MAX_TRIES(3), .LOCKOUT_TICKS(5)
    ) dut (
        .clk_in(clk_in), .rst(rst), .tick(tick), .clear(clear), .enter(enter),
        .change(change), .sw(sw), .entry_buf(entry_buf), .entry_cnt(entry_cnt),
        .unlocked(unlocked), .locked_out(locked_out), .changing(changing),
        .fail_cnt(fail_cnt), .ok_pulse(ok_pulse), .err_pulse(err_pulse)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0, errors = 0;

    localparam int M_LOCKED = 0, M_CHECK = 1, M_OPEN = 2, M_NEW = 3, M_CONF = 4, M_LOCKOUT = 5;
    int          m_mode = M_LOCKED;
    int          q[$];
    logic [15:0] m_code = 16'h1234, m_saved = '0;
    int          m_fail = 0, m_ticks = 0;
    bit          m_ok = 0, m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] val();
        logic [15:0] v;
        v = '0;
        foreach (q[i]) v = (v << 4) | 16'(q[i]);
        return v;
    endfunction

    task automatic m_reset();
        m_mode = M_LOCKED; q.delete(); m_code = 16'h1234; m_saved = '0;
        m_fail = 0; m_ticks = 0; m_ok = 0; m_err = 0;
    endtask

    task automatic m_step();
        int n;
        bit take;
        n = q.size();
        m_ok = 0;
        m_err = 0;
        take = enter && !clear && !change && n < 4 &&
               (m_mode == M_LOCKED || m_mode == M_NEW || m_mode == M_CONF);
        if (take) begin
            if (sw > 9) m_err = 1;
            else q.push_back(int'(sw));
        end
        case (m_mode)
            M_LOCKED: if (clear) q.delete(); else if (n == 4) m_mode = M_CHECK;
            M_CHECK: begin
                if (val() == m_code) begin
                    m_mode = M_OPEN; m_ok = 1; m_fail = 0;
                end else begin
                    m_err = 1;
                    if (m_fail < 3) m_fail++;
                    m_mode = (m_fail == 3) ? M_LOCKOUT : M_LOCKED;
                end
                q.delete();
            end
            M_OPEN: if (clear) m_mode = M_LOCKED;
                    else if (change) begin m_mode = M_NEW; q.delete(); end
            M_NEW: if (clear) begin m_mode = M_OPEN; q.delete(); end
                   else if (n == 4) begin m_saved = val(); q.delete(); m_mode = M_CONF; end
            M_CONF: if (clear) begin m_mode = M_OPEN; q.delete(); end
                    else if (n == 4) begin
                        if (val() == m_saved) begin m_code = val(); m_ok = 1; end
                        else m_err = 1;
                        m_mode = M_OPEN;
                        q.delete();
                    end
            M_LOCKOUT: if (tick) begin
                m_ticks++;
                if (m_ticks == 5) begin m_mode = M_LOCKED; m_fail = 0; m_ticks = 0; end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk_in) begin
        if (!rst) m_reset();
        else m_step();
        #1;
        chk("entry_buf", entry_buf, val());
        chk("entry_cnt", entry_cnt, q.size());
        chk("unlocked", unlocked, m_mode == M_OPEN || m_mode == M_NEW || m_mode == M_CONF);
        chk("locked_out", locked_out, m_mode == M_LOCKOUT);
        chk("changing", changing, m_mode == M_NEW || m_mode == M_CONF);
        chk("fail_cnt", fail_cnt, m_fail);
        chk("ok_pulse", ok_pulse, m_ok);
        chk("err_pulse", err_pulse, m_err);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic key(input logic [3:0] d);
        enter = 1'b1; sw = d;
        @(negedge clk_in);
        enter = 1'b0;
    endtask

    task automatic keys(input logic [15:0] c);
        for (int i = 0; i < 4; i++) key(c[15-4*i -: 4]);
    endtask

    task automatic press_clear();
        clear = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;
    endtask

    task automatic press_change();
        change = 1'b1;
        @(negedge clk_in);
        change = 1'b0;
    endtask

    function automatic logic [3:0] target();
        int n;
        logic [15:0] src;
        n = q.size();
        src = (m_mode == M_CONF) ? m_saved : m_code;
        if (n >= 4) return 4'($urandom_range(0, 11));
        return src[15-4*n -: 4];
    endfunction

    initial begin
        idle(2);
        chk("rst_unlocked", unlocked, 0);
        chk("rst_cnt", entry_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_ok", ok_pulse, 0);
        chk("rst_err", err_pulse, 0);
        rst = 1'b1;
        keys(16'h1234);
        chk("buf_1234", entry_buf, 16'h1234);
        idle(1);
        chk("ok_not_yet", ok_pulse, 0);
        idle(1);
        chk("unlock_ok", ok_pulse, 1);
        chk("unlock_open", unlocked, 1);
        press_clear();
        chk("relock", unlocked, 0);
        for (int i = 1; i <= 3; i++) begin
            keys(16'h1235);
            idle(2);
            chk("wrong_err", err_pulse, 1);
            chk("wrong_fail", fail_cnt, i);
        end
        chk("lockout", locked_out, 1);
        key(4'h1);
        chk("lockout_ignore", entry_cnt, 0);
        repeat (4) begin tick = 1'b1; @(negedge clk_in); tick = 1'b0; end
        chk("lockout_hold", locked_out, 1);
        tick = 1'b1; @(negedge clk_in); tick = 1'b0;
        chk("lockout_end", locked_out, 0);
        chk("lockout_fail", fail_cnt, 0);
        key(4'hA);
        chk("illegal_err", err_pulse, 1);
        chk("illegal_cnt", entry_cnt, 0);
        chk("illegal_fail", fail_cnt, 0);
        keys(16'h1234);
        idle(2);
        press_change();
        chk("changing", changing, 1);
        keys(16'h9876);
        idle(1);
        keys(16'h9876);
        idle(1);
        chk("chg_ok", ok_pulse, 1);
        chk("chg_done", changing, 0);
        press_clear();
        keys(16'h1234);
        idle(2);
        chk("old_code_err", err_pulse, 1);
        keys(16'h9876);
        idle(2);
        chk("new_code_ok", ok_pulse, 1);
        press_change();
        keys(16'h9876);
        idle(1);
        keys(16'h9875);
        idle(1);
        chk("conf_err", err_pulse, 1);
        chk("conf_open", unlocked, 1);
        press_clear();
        keys(16'h9876);
        idle(2);
        chk("kept_ok", ok_pulse, 1);
        press_clear();
        key(4'h1);
        key(4'h2);
        clear = 1'b1; enter = 1'b1; sw = 4'h3;
        @(negedge clk_in);
        clear = 1'b0; enter = 1'b0;
        chk("prio_cnt", entry_cnt, 0);
        chk("prio_buf", entry_buf, 0);
        keys(16'h9876);
        idle(2);
        change = 1'b1; clear = 1'b1;
        @(negedge clk_in);
        change = 1'b0; clear = 1'b0;
        chk("prio_lock", unlocked, 0);
        keys(16'h9876);
        idle(2);
        press_change();
        keys(16'h1111);
        idle(1);
        key(4'h1);
        key(4'h1);
        chk("conf_cnt", entry_cnt, 2);
        rst = 1'b0;
        @(negedge clk_in);
        rst = 1'b1;
        chk("rst2_unlocked", unlocked, 0);
        chk("rst2_buf", entry_buf, 0);
        keys(16'h1234);
        idle(2);
        chk("default_ok", ok_pulse, 1);
        press_clear();
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            clear  = r < 3;
            change = r >= 3 && r < 8;
            enter  = (r >= 8 && r < 55) || $urandom_range(0, 19) == 0;
            tick   = $urandom_range(0, 2) == 0;
            sw     = $urandom_range(0, 2) != 0 ? target() : 4'($urandom_range(0, 11));
            rst    = $urandom_range(0, 799) != 0;
            @(negedge clk_in);
        end
        {clear, change, enter, tick} = '0;
        rst = 1'b1;
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
